keypad_encoder: RTL and testbench

//  Front end of the countdown timer's load interface. Scans 10 raw keypad buttons (digits 0-9).

---
 rtl/keypad_encoder.sv | 130 +++++++++++++
 tb/tb_keypad_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad front end: emits one BCD digit per clean press on number/loadn.
// Define KEYPAD_DIGIT_LIMIT_EN to cap an entry at MAX_DIGITS pulses until digit_clear re-arms it.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       enable,
  input  logic [9:0] keypad,
  input  logic       digit_clear,
  output logic [3:0] number,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PULSE, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code;
  logic [9:0]       kmeta;
  logic [9:0]       ksync;
  logic             key_any;
  logic [3:0]       key_code;
  logic             limit_hit;
  logic             limit_block;
  logic             clear_req;

  function automatic logic [3:0] enc(input logic [9:0] k);
    enc = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) enc = 4'(i);
    end
  endfunction

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      kmeta <= '0;
      ksync <= '0;
    end else begin
      kmeta <= keypad;
      ksync <= kmeta;
    end
  end

  assign key_any   = |ksync;
  assign key_code  = enc(ksync);
  assign limit_hit = 32'(digit_count) >= MAX_DIGITS;

`ifdef KEYPAD_DIGIT_LIMIT_EN
  assign limit_block = limit_hit;
  assign clear_req   = digit_clear;
`else
  logic unused_ok;
  assign limit_block = 1'b0;
  assign clear_req   = 1'b0;
  assign unused_ok   = digit_clear ^ limit_hit;
`endif

  // A limited press is still debounced and released so it can never leak into the next entry.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state       <= IDLE;
      cnt         <= '0;
      code        <= 4'd0;
      number      <= 4'd0;
      loadn       <= 1'b1;
      busy        <= 1'b0;
      digit_count <= 2'd0;
    end else begin
      loadn <= 1'b1;
      if (clear_req) begin
        digit_count <= 2'd0;
      end else if (state == PULSE && digit_count != 2'd3) begin
        digit_count <= digit_count + 2'd1;
      end
      case (state)
        IDLE: begin
          if (enable && key_any) begin
            code  <= key_code;
            cnt   <= CNT_W'(1);
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!key_any || key_code != code) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == DB_MAX) begin
            if (limit_block) begin
              cnt   <= '0;
              state <= WAIT_REL;
            end else begin
              number <= code;
              loadn  <= 1'b0;
              state  <= PULSE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PULSE: begin
          cnt   <= '0;
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (key_any) begin
            cnt <= '0;
          end else if (cnt == DB_MAX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: reset, latency, bounce, priority/enable, digit entry, mid-operation reset.
module tb_keypad_encoder;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic       enable = 1'b0;
  logic       digit_clear = 1'b0;
  logic [9:0] keypad = '0;
  logic [3:0] number;
  logic       loadn;
  logic [1:0] digit_count;
  logic       busy;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         pulse_count = 0;
  logic [3:0] pulse_number = 4'd0;

  typedef struct {
    logic [9:0] keys;
    logic       en;
    int         pulses;
    logic [3:0] num;
    logic [1:0] cnt;
  } vec_t;

  keypad_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(8),
    .MAX_DIGITS(3)
  ) dut (
    .clock(clock),
    .clearn(clearn),
    .enable(enable),
    .keypad(keypad),
    .digit_clear(digit_clear),
    .number(number),
    .loadn(loadn),
    .digit_count(digit_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!loadn) begin
      pulse_count = pulse_count + 1;
      pulse_number = number;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_output({name, " returns idle"}, int'(busy), 0);
  endtask

  task automatic do_reset();
    clearn = 1'b0;
    keypad = '0;
    digit_clear = 1'b0;
    tick();
    tick();
    clearn = 1'b1;
    tick();
  endtask

  task automatic apply_stimulus(input logic [9:0] keys, input logic en, input int hold, input string name);
    enable = en;
    keypad = keys;
    repeat (hold) tick();
    keypad = '0;
    repeat (3) tick();
    wait_idle(name);
    enable = 1'b1;
  endtask

  // {number, loadn, digit_count, busy} packed: reset value is 0000_1_00_0.
  function automatic int out_word();
    return int'({number, loadn, digit_count, busy});
  endfunction

  initial begin
    vec_t vecs[6];
    int base;
    int first;

    vecs[0] = '{keys: 10'h020, en: 1'b1, pulses: 1, num: 4'd5, cnt: 2'd1};
    vecs[1] = '{keys: 10'h088, en: 1'b1, pulses: 1, num: 4'd7, cnt: 2'd1};
    vecs[2] = '{keys: 10'h002, en: 1'b0, pulses: 0, num: 4'd0, cnt: 2'd0};
    vecs[3] = '{keys: 10'h001, en: 1'b1, pulses: 1, num: 4'd0, cnt: 2'd1};
    vecs[4] = '{keys: 10'h200, en: 1'b1, pulses: 1, num: 4'd9, cnt: 2'd1};
    vecs[5] = '{keys: 10'h3FF, en: 1'b1, pulses: 1, num: 4'd9, cnt: 2'd1};

    // Reset held with every key down: outputs must stay at reset values.
    clearn = 1'b0;
    enable = 1'b1;
    keypad = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("reset outputs", out_word(), 8);
    end
    keypad = '0;
    clearn = 1'b1;
    tick();

    // Single press latency: driven just after edge E0, loadn low right after edge E0+7.
    do_reset();
    base = pulse_count;
    first = -1;
    keypad = 10'h020;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!loadn && first < 0) first = i;
    end
    check_output("press latency", first, 7);
    repeat (10) tick();
    keypad = '0;
    repeat (3) tick();
    wait_idle("single press");
    check_output("single press pulses", pulse_count - base, 1);
    check_output("single press number", int'(number), 5);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = pulse_count;
      apply_stimulus(vecs[v].keys, vecs[v].en, 20, "table");
      check_output("table pulses", pulse_count - base, vecs[v].pulses);
      check_output("table number", int'(number), int'(vecs[v].num));
      check_output("table digit_count", int'(digit_count), int'(vecs[v].cnt));
    end

    // Bouncing key: two-cycle runs never satisfy the debounce window.
    do_reset();
    base = pulse_count;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      keypad = ((i / 2) % 2 == 0) ? 10'h004 : 10'h000;
      tick();
    end
    check_output("bounce no pulse", pulse_count - base, 0);
    keypad = 10'h004;
    repeat (20) tick();
    keypad = '0;
    repeat (3) tick();
    wait_idle("bounce");
    check_output("bounce pulses", pulse_count - base, 1);
    check_output("bounce number", int'(pulse_number), 2);

    // Entry of 1,2,5 then 9, then digit_clear and 9 again.
    do_reset();
    base = pulse_count;
    apply_stimulus(10'h002, 1'b1, 12, "entry 1");
    apply_stimulus(10'h004, 1'b1, 12, "entry 2");
    apply_stimulus(10'h020, 1'b1, 12, "entry 5");
    apply_stimulus(10'h200, 1'b1, 12, "entry 9");
`ifdef KEYPAD_DIGIT_LIMIT_EN
    check_output("entry pulses", pulse_count - base, 3);
    check_output("entry number", int'(number), 5);
`else
    check_output("entry pulses", pulse_count - base, 4);
    check_output("entry number", int'(number), 9);
`endif
    check_output("entry digit_count", int'(digit_count), 3);
    digit_clear = 1'b1;
    tick();
    digit_clear = 1'b0;
    tick();
`ifdef KEYPAD_DIGIT_LIMIT_EN
    check_output("digit_clear count", int'(digit_count), 0);
`else
    check_output("digit_clear count", int'(digit_count), 3);
`endif
    base = pulse_count;
    apply_stimulus(10'h200, 1'b1, 12, "entry 9 again");
    check_output("re-armed pulses", pulse_count - base, 1);
    check_output("re-armed number", int'(number), 9);

    // Reset during DEBOUNCE after a completed press of 8.
    do_reset();
    apply_stimulus(10'h100, 1'b1, 20, "pre press");
    check_output("pre press number", int'(number), 8);
    base = pulse_count;
    keypad = 10'h010;
    repeat (4) tick();
    clearn = 1'b0;
    tick();
    check_output("reset in debounce", out_word(), 8);
    keypad = '0;
    tick();
    clearn = 1'b1;
    tick();
    check_output("debounce reset pulses", pulse_count - base, 0);

    // Reset during WAIT_REL while key still held.
    keypad = 10'h040;
    repeat (10) tick();
    check_output("wait_rel press pulses", pulse_count - base, 1);
    clearn = 1'b0;
    tick();
    check_output("reset in wait_rel", out_word(), 8);
    keypad = '0;
    tick();
    clearn = 1'b1;
    tick();
    apply_stimulus(10'h008, 1'b1, 20, "after reset");
    check_output("after reset pulses", pulse_count - base, 2);
    check_output("after reset number", int'(number), 3);
    check_output("after reset digit_count", int'(digit_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
